// File: rtl/sync_fifo_pkg.sv
// Shared FIFO definitions: access-mode encoding, read-latency (FWFT) encoding
// and the depth of the stream reader's holding buffer.
package sync_fifo_pkg;

    typedef enum logic [1:0] {
        FIFO_ACC_NONE  = 2'b00,
        FIFO_ACC_READ  = 2'b01,
        FIFO_ACC_WRITE = 2'b10,
        FIFO_ACC_BOTH  = 2'b11
    } fifo_access_e;

    localparam int FWFT_REGISTERED = 0;
    localparam int FWFT_SAME_CYCLE = 1;

    localparam int BUF_DEPTH = 2;

    function automatic fifo_access_e buf_access(input logic wr, input logic rd);
        return fifo_access_e'({wr, rd});
    endfunction

endpackage

// File: rtl/fifo_reader_buffer.sv
// Two-entry in-order holding buffer; head_o is always the oldest stored word.
module fifo_reader_buffer
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clear_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [1:0]            level_o
);

    logic [DATA_WIDTH-1:0] word0_q, word0_d;
    logic [DATA_WIDTH-1:0] word1_q, word1_d;
    logic [1:0]            level_q, level_d;

    always_comb begin
        word0_d = word0_q;
        word1_d = word1_q;
        level_d = level_q;
        if (clear_i) begin
            level_d = 2'd0;
        end else begin
            case (buf_access(push_i, pop_i))
                FIFO_ACC_READ: begin
                    word0_d = word1_q;
                    level_d = level_q - 2'd1;
                end
                FIFO_ACC_WRITE: begin
                    if (level_q == 2'd0) begin
                        word0_d = push_data_i;
                    end else begin
                        word1_d = push_data_i;
                    end
                    level_d = level_q + 2'd1;
                end
                FIFO_ACC_BOTH: begin
                    // Shift and append; a single held word is simply replaced.
                    if (level_q == 2'd1) begin
                        word0_d = push_data_i;
                    end else begin
                        word0_d = word1_q;
                        word1_d = push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            word0_q <= '0;
            word1_q <= '0;
            level_q <= 2'd0;
        end else begin
            word0_q <= word0_d;
            word1_q <= word1_d;
            level_q <= level_d;
        end
    end

    assign head_o  = word0_q;
    assign level_o = level_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a source FIFO into a valid/ready stream through a 2-word buffer,
// issuing reads on credit so no word is ever dropped or overrun.
module fifo_stream_reader
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FWFT       = FWFT_REGISTERED
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_read_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic [1:0]            level_o
);

    localparam bit            IS_FWFT    = (FWFT == FWFT_SAME_CYCLE);
    localparam logic [2:0]    CREDIT_MAX = 3'(BUF_DEPTH - 1);

    logic       in_flight_q, in_flight_d;
    logic [1:0] level;
    logic       pop;
    logic       credit_ok;
    logic       capture;

    assign m_valid_o = (level != 2'd0);
    assign pop       = m_valid_o & m_ready_i;
    assign credit_ok = ({1'b0, level} + {2'b00, in_flight_q}) <= CREDIT_MAX;

    // A same-cycle pop frees a slot, so ready feeds the read strobe directly.
    assign fifo_read_o = rst_n_i & ~fifo_empty_i & ~flush_i & (credit_ok | pop);

    assign capture = IS_FWFT ? fifo_read_o : in_flight_q;

    always_comb begin
        in_flight_d = 1'b0;
        if (!IS_FWFT && !flush_i) begin
            in_flight_d = fifo_read_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            in_flight_q <= 1'b0;
        end else begin
            in_flight_q <= in_flight_d;
        end
    end

    fifo_reader_buffer #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buffer (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .clear_i     (flush_i),
        .push_i      (capture),
        .push_data_i (fifo_rd_data_i),
        .pop_i       (pop),
        .head_o      (m_data_o),
        .level_o     (level)
    );

    assign level_o = level;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Drives a registered-read and a same-cycle-read reader side by side from
// queue-based source FIFOs; a monitor scores every handshake in order.
module tb_fifo_stream_reader;

    localparam int DW = 32;

    logic          clk_i     = 1'b0;
    logic          rst_n_i   = 1'b0;
    logic          flush_i   = 1'b0;
    logic          m_ready_i = 1'b0;
    logic          fifo_empty_i   [2];
    logic          fifo_read_o    [2];
    logic [DW-1:0] fifo_rd_data_i [2];
    logic          m_valid_o      [2];
    logic [DW-1:0] m_data_o       [2];
    logic [1:0]    level_o        [2];

    fifo_stream_reader #(.DATA_WIDTH(DW), .FWFT(0)) dut0 (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .flush_i        (flush_i),
        .fifo_empty_i   (fifo_empty_i[0]),
        .fifo_read_o    (fifo_read_o[0]),
        .fifo_rd_data_i (fifo_rd_data_i[0]),
        .m_valid_o      (m_valid_o[0]),
        .m_ready_i      (m_ready_i),
        .m_data_o       (m_data_o[0]),
        .level_o        (level_o[0])
    );

    fifo_stream_reader #(.DATA_WIDTH(DW), .FWFT(1)) dut1 (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .flush_i        (flush_i),
        .fifo_empty_i   (fifo_empty_i[1]),
        .fifo_read_o    (fifo_read_o[1]),
        .fifo_rd_data_i (fifo_rd_data_i[1]),
        .m_valid_o      (m_valid_o[1]),
        .m_ready_i      (m_ready_i),
        .m_data_o       (m_data_o[1]),
        .level_o        (level_o[1])
    );

    always #5 clk_i = ~clk_i;

    logic [DW-1:0] src_q [2][$];
    logic [DW-1:0] exp_q [2][$];
    logic          pend_pop   [2];
    logic          stall      [2];
    logic [DW-1:0] stall_data [2];
    int            first_rd [2], first_vld [2], last_vld [2];
    int            nreads [2], nvalid [2];
    int            cyc    = 0;
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] mon_exp;

    // Scoreboard monitor: every accepted word must be the next word fetched.
    always @(posedge clk_i) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n_i && m_valid_o[d] && m_ready_i) begin
                checks++;
                if (exp_q[d].size() == 0) begin
                    errors++;
                    $display("FAIL dut%0d_extra_word: got %h, required no word", d, m_data_o[d]);
                end else begin
                    mon_exp = exp_q[d].pop_front();
                    if (m_data_o[d] !== mon_exp) begin
                        errors++;
                        $display("FAIL dut%0d_word_order: got %h, required %h", d, m_data_o[d], mon_exp);
                    end
                end
            end
            if (flush_i) exp_q[d].delete();
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic clear_stats();
        for (int d = 0; d < 2; d++) begin
            first_rd[d] = -1; first_vld[d] = -1; last_vld[d] = -1;
            nreads[d] = 0; nvalid[d] = 0;
        end
    endtask

    // One clock cycle: source model advances, inputs applied, outputs sampled.
    task automatic step(input logic rdy, input logic fl);
        logic [DW-1:0] w, w2;
        logic          hs;
        @(negedge clk_i);
        cyc++;
        for (int d = 0; d < 2; d++) begin
            w = $urandom;
            if (pend_pop[d]) begin
                w2 = src_q[d].pop_front();
                if (d == 0) w = w2;
                pend_pop[d] = 1'b0;
            end
            if (d == 1 && src_q[d].size() > 0) w = src_q[d][0];
            fifo_rd_data_i[d] = w;
            fifo_empty_i[d]   = (src_q[d].size() == 0);
        end
        m_ready_i = rdy;
        flush_i   = fl;
        #1;
        for (int d = 0; d < 2; d++) begin
            hs = m_valid_o[d] && m_ready_i;
            if (fifo_empty_i[d]) begin
                checks++;
                if (fifo_read_o[d]) begin
                    errors++;
                    $display("FAIL dut%0d_read_when_empty: fifo_read_o=1, required 0", d);
                end
            end
            if (level_o[d] == 2'd2 && !hs) begin
                checks++;
                if (fifo_read_o[d]) begin
                    errors++;
                    $display("FAIL dut%0d_read_when_full: fifo_read_o=1, required 0", d);
                end
            end
            if (stall[d]) begin
                checks++;
                if (!m_valid_o[d] || m_data_o[d] !== stall_data[d]) begin
                    errors++;
                    $display("FAIL dut%0d_stall_hold: valid=%0b data=%h, required valid=1 data=%h",
                             d, m_valid_o[d], m_data_o[d], stall_data[d]);
                end
            end
            stall[d]      = m_valid_o[d] && !m_ready_i && !flush_i;
            stall_data[d] = m_data_o[d];
            if (fifo_read_o[d] && !fifo_empty_i[d]) begin
                pend_pop[d] = 1'b1;
                exp_q[d].push_back(src_q[d][0]);
                nreads[d]++;
                if (first_rd[d] < 0) first_rd[d] = cyc;
            end
            if (m_valid_o[d]) begin
                nvalid[d]++;
                if (first_vld[d] < 0) first_vld[d] = cyc;
                last_vld[d] = cyc;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_%s_valid", d, tag), m_valid_o[d], 0);
            chk($sformatf("dut%0d_%s_level", d, tag), level_o[d], 0);
            chk($sformatf("dut%0d_%s_read", d, tag), fifo_read_o[d], 0);
            chk($sformatf("dut%0d_%s_data", d, tag), m_data_o[d], 0);
        end
    endtask

    task automatic async_reset();
        @(negedge clk_i);
        #2;
        rst_n_i = 1'b0;
        #1;
        check_reset_outputs("midrst");
        for (int d = 0; d < 2; d++) begin
            exp_q[d].delete();
            pend_pop[d]     = 1'b0;
            stall[d]        = 1'b0;
            fifo_empty_i[d] = 1'b1;
        end
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;
    endtask

    task automatic check_drained(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_%s_pending", d, tag), exp_q[d].size(), 0);
            chk($sformatf("dut%0d_%s_src_left", d, tag), src_q[d].size(), 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            fifo_empty_i[d]   = 1'b1;
            fifo_rd_data_i[d] = '0;
            pend_pop[d]       = 1'b0;
            stall[d]          = 1'b0;
        end
        clear_stats();
        #2;
        check_reset_outputs("rst");
        repeat (2) @(negedge clk_i);
        rst_n_i = 1'b1;

        // Three preloaded words, consumer always ready.
        clear_stats();
        for (int d = 0; d < 2; d++) begin
            src_q[d].push_back(32'h11);
            src_q[d].push_back(32'h22);
            src_q[d].push_back(32'h33);
        end
        repeat (8) step(1'b1, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_latency", d), first_vld[d] - first_rd[d], (d == 0) ? 2 : 1);
            chk($sformatf("dut%0d_valid_cycles", d), nvalid[d], 3);
            chk($sformatf("dut%0d_no_gaps", d), last_vld[d] - first_vld[d], 2);
        end
        check_drained("burst3");

        // Backpressure with five words waiting.
        clear_stats();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 5; i++) src_q[d].push_back(32'hA0 + i);
        repeat (6) step(1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_bp_reads", d), nreads[d], 2);
            chk($sformatf("dut%0d_bp_level", d), level_o[d], 2);
            chk($sformatf("dut%0d_bp_head", d), m_data_o[d], 32'hA0);
        end
        repeat (10) step(1'b1, 1'b0);
        check_drained("bp");

        // Single word with a toggling consumer.
        for (int d = 0; d < 2; d++) src_q[d].push_back(32'h5A5A_0001);
        for (int i = 0; i < 8; i++) step(i[0], 1'b0);
        check_drained("single");

        // Flush in the cycle after the first read.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 4; i++) src_q[d].push_back(32'hC0 + i);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_flush_valid", d), m_valid_o[d], 0);
            chk($sformatf("dut%0d_flush_level", d), level_o[d], 0);
        end
        repeat (8) step(1'b1, 1'b0);
        check_drained("flush");

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            for (int d = 0; d < 2; d++)
                if ($urandom_range(0, 3) == 0) src_q[d].push_back($urandom);
            step($urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);
        end
        for (int i = 0; i < 80; i++) begin
            if (src_q[0].size() == 0 && src_q[1].size() == 0 &&
                exp_q[0].size() == 0 && exp_q[1].size() == 0) break;
            step(1'b1, 1'b0);
        end
        check_drained("random");

        // Asynchronous reset with a full buffer, then normal operation.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 5; i++) src_q[d].push_back(32'hE0 + i);
        repeat (4) step(1'b0, 1'b0);
        for (int d = 0; d < 2; d++)
            chk($sformatf("dut%0d_prerst_level", d), level_o[d], 2);
        async_reset();
        clear_stats();
        repeat (10) step(1'b1, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d_postrst_valid_cycles", d), nvalid[d], 3);
            chk($sformatf("dut%0d_postrst_latency", d), first_vld[d] - first_rd[d], (d == 0) ? 2 : 1);
        end
        check_drained("postrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
